// File: rtl/shot_if.sv
// Key, switch and fire-result signals between the player panel and the shot controller.
interface shot_if;
  logic       key_left;
  logic       key_right;
  logic       key_fire;
  logic [1:0] shootingtype;
  logic [3:0] hit_angle;
  logic       outgoing_projectiles;
  logic [1:0] shot_type;
  logic       busy;
  logic [3:0] laser_charges;
  logic [15:0] shots_fired;

  modport master (
    output key_left, key_right, key_fire, shootingtype,
    input  hit_angle, outgoing_projectiles, shot_type, busy, laser_charges, shots_fired
  );

  modport slave (
    input  key_left, key_right, key_fire, shootingtype,
    output hit_angle, outgoing_projectiles, shot_type, busy, laser_charges, shots_fired
  );
endinterface

// File: rtl/shot_controller.sv
// Player fire stage: debounced rotate/fire keys, turret aim, fire pulse, per-weapon cooldown.
//   state    | meaning
//   IDLE     | waiting for an acceptable fire event
//   FIRE     | outgoing_projectiles pulse cycle, shot counted
//   COOLDOWN | down-counter runs to zero, fire events dropped
module shot_controller #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned COOLDOWN_T1     = 12500000,
  parameter int unsigned COOLDOWN_T2     = 25000000,
  parameter int unsigned COOLDOWN_T3     = 50000000,
  parameter int unsigned LASER_CHARGES   = 3
) (
  input logic   clk,
  input logic   reset,
  shot_if.slave bus
);

  localparam int unsigned DEB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned CD_MAX =
    (COOLDOWN_T1 > COOLDOWN_T2) ? ((COOLDOWN_T1 > COOLDOWN_T3) ? COOLDOWN_T1 : COOLDOWN_T3)
                                : ((COOLDOWN_T2 > COOLDOWN_T3) ? COOLDOWN_T2 : COOLDOWN_T3);
  localparam int unsigned CD_W   = $clog2(CD_MAX + 1);
  localparam logic [DEB_W-1:0] DEB_TC = DEB_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, FIRE, COOLDOWN} state_e;

  // bit 0 = left, bit 1 = right, bit 2 = fire
  logic [2:0]            raw;
  logic [2:0]            sync1_q, sync2_q, deb_q, ev_q;
  logic [2:0][DEB_W-1:0] deb_cnt_q;

  assign raw = {bus.key_fire, bus.key_right, bus.key_left};

  // The counter only runs while a level change is pending; any bounce back restarts it.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      deb_q     <= '0;
      ev_q      <= '0;
      deb_cnt_q <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      for (int k = 0; k < 3; k++) begin
        ev_q[k] <= 1'b0;
        if (sync2_q[k] == deb_q[k]) begin
          deb_cnt_q[k] <= '0;
        end else if (deb_cnt_q[k] == DEB_TC) begin
          deb_q[k]     <= sync2_q[k];
          ev_q[k]      <= sync2_q[k];
          deb_cnt_q[k] <= '0;
        end else begin
          deb_cnt_q[k] <= deb_cnt_q[k] + DEB_W'(1);
        end
      end
    end
  end

  state_e          state_q;
  logic [CD_W-1:0] cd_q;
  logic [3:0]      angle_q, pend_q, charges_q;
  logic [1:0]      shot_type_q;
  logic            pulse_q, busy_q;
  logic [15:0]     shots_q;

  logic [3:0]      rot_d;
  logic [CD_W-1:0] cd_load_d;
  logic            accept_d;

  always_comb begin
    rot_d = 4'd0;
    case (ev_q[1:0])
      2'b10:   rot_d = 4'd1;
      2'b01:   rot_d = 4'hF;
      default: rot_d = 4'd0;
    endcase
    cd_load_d = CD_W'(COOLDOWN_T3 - 1);
    case (bus.shootingtype)
      2'd1:    cd_load_d = CD_W'(COOLDOWN_T1 - 1);
      2'd2:    cd_load_d = CD_W'(COOLDOWN_T2 - 1);
      default: cd_load_d = CD_W'(COOLDOWN_T3 - 1);
    endcase
    accept_d = (state_q == IDLE) && ev_q[2] && (bus.shootingtype != 2'd0) &&
               !((bus.shootingtype == 2'd3) && (charges_q == 4'd0));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cd_q        <= '0;
      angle_q     <= 4'd0;
      pend_q      <= 4'd0;
      charges_q   <= 4'(LASER_CHARGES);
      shot_type_q <= 2'd0;
      pulse_q     <= 1'b0;
      busy_q      <= 1'b0;
      shots_q     <= 16'd0;
    end else begin
      pulse_q <= 1'b0;
      // The aim seen by the enemy during the pulse is frozen at acceptance; a rotation
      // arriving in that same cycle is parked and applied during FIRE.
      if (accept_d) begin
        pend_q <= rot_d;
      end else if (state_q == FIRE) begin
        angle_q <= angle_q + pend_q + rot_d;
        pend_q  <= 4'd0;
      end else begin
        angle_q <= angle_q + rot_d;
      end

      case (state_q)
        IDLE: begin
          if (accept_d) begin
            state_q     <= FIRE;
            busy_q      <= 1'b1;
            pulse_q     <= 1'b1;
            shot_type_q <= bus.shootingtype;
            cd_q        <= cd_load_d;
            if (bus.shootingtype == 2'd3) charges_q <= charges_q - 4'd1;
          end
        end
        FIRE: begin
          state_q <= COOLDOWN;
          if (shots_q != 16'hFFFF) shots_q <= shots_q + 16'd1;
        end
        COOLDOWN: begin
          if (cd_q == '0) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            cd_q <= cd_q - CD_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.hit_angle            = angle_q;
  assign bus.outgoing_projectiles = pulse_q;
  assign bus.shot_type            = shot_type_q;
  assign bus.busy                 = busy_q;
  assign bus.laser_charges        = charges_q;
  assign bus.shots_fired          = shots_q;

endmodule

// File: tb/tb_shot_controller.sv
// Scoreboard bench for shot_controller: directed scenarios followed by random key/switch traffic.
module tb_shot_controller;
  localparam int DEB = 4;
  localparam int T1  = 10;
  localparam int T2  = 20;
  localparam int T3  = 30;
  localparam int LC  = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  shot_if sif();

  shot_controller #(
    .DEBOUNCE_CYCLES(DEB), .COOLDOWN_T1(T1), .COOLDOWN_T2(T2),
    .COOLDOWN_T3(T3), .LASER_CHARGES(LC)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(sif.slave)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    int cyc;
    int typ;
    int ang;
    int shots;
    int chg;
  } exp_t;
  exp_t exp_q[$];

  // Reference model state, advanced by the driver as each key action is issued
  int m_angle = 0;
  int m_chg = LC;
  int m_shots = 0;
  int m_type = 0;
  int m_last_type = 0;
  int m_idle_from = 0;

  function automatic int cool(input int t);
    return (t == 1) ? T1 : (t == 2) ? T2 : T3;
  endfunction

  task automatic check(input string name, input int act, input int expv);
    n_checks++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Monitor: pops the expected pulse when its cycle comes, tracks the busy window
  int win_lo = -1;
  int win_hi = -2;
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        exp_q.delete();
        win_lo = -1;
        win_hi = -2;
        check("rst_hit_angle", sif.hit_angle, 0);
        check("rst_pulse", sif.outgoing_projectiles, 0);
        check("rst_shot_type", sif.shot_type, 0);
        check("rst_busy", sif.busy, 0);
        check("rst_laser_charges", sif.laser_charges, LC);
        check("rst_shots_fired", sif.shots_fired, 0);
      end else begin
        if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
          e = exp_q.pop_front();
          check("pulse_expected", sif.outgoing_projectiles, 1);
          check("pulse_shot_type", sif.shot_type, e.typ);
          check("pulse_hit_angle", sif.hit_angle, e.ang);
          check("pulse_shots_fired", sif.shots_fired, e.shots);
          check("pulse_laser_charges", sif.laser_charges, e.chg);
          win_lo = cyc;
          win_hi = cyc + cool(e.typ);
        end else begin
          check("no_pulse", sif.outgoing_projectiles, 0);
        end
        check("busy", sif.busy, (cyc >= win_lo && cyc <= win_hi) ? 1 : 0);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic end_checks();
    check("angle", sif.hit_angle, m_angle);
    check("shots_fired", sif.shots_fired, m_shots);
    check("laser_charges", sif.laser_charges, m_chg);
    check("shot_type", sif.shot_type, m_last_type);
  endtask

  // Raw keys rise now (cycle k); a press held DEB cycles becomes an event in cycle k+DEB+2.
  task automatic press(input bit l, input bit r, input bit f, input int hold, input int gap);
    int   e;
    exp_t x;
    e = cyc + DEB + 2;
    sif.key_left  = l;
    sif.key_right = r;
    sif.key_fire  = f;
    if (hold >= DEB) begin
      if (f && m_type != 0 && !(m_type == 3 && m_chg == 0) && e >= m_idle_from) begin
        if (m_type == 3) m_chg--;
        x.cyc   = e + 1;
        x.typ   = m_type;
        x.ang   = m_angle;
        x.shots = m_shots;
        x.chg   = m_chg;
        exp_q.push_back(x);
        if (m_shots < 65535) m_shots++;
        m_last_type = m_type;
        m_idle_from = e + 2 + cool(m_type);
      end
      if (l && !r) m_angle = (m_angle + 15) % 16;
      else if (r && !l) m_angle = (m_angle + 1) % 16;
    end
    tick(hold);
    sif.key_left  = 1'b0;
    sif.key_right = 1'b0;
    sif.key_fire  = 1'b0;
    tick(gap);
    end_checks();
  endtask

  task automatic set_type(input int t);
    sif.shootingtype = 2'(t);
    m_type = t;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    m_angle = 0;
    m_chg = LC;
    m_shots = 0;
    m_last_type = 0;
    m_idle_from = 0;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin : driver
    sif.key_left = 1'b0;
    sif.key_right = 1'b0;
    sif.key_fire = 1'b0;
    sif.shootingtype = 2'd0;
    tick(3);
    reset = 1'b0;
    tick(2);

    // Short glitch, then a held press with exact event timing
    press(0, 1, 0, 3, 10);
    sif.key_right = 1'b1;
    repeat (6) @(posedge clk);
    #1 check("right_before_t7", sif.hit_angle, m_angle);
    @(posedge clk);
    #1 check("right_at_t7", sif.hit_angle, (m_angle + 1) % 16);
    m_angle = (m_angle + 1) % 16;
    repeat (4) @(negedge clk);
    sif.key_right = 1'b0;
    tick(10);
    end_checks();

    // Wrap both ways, simultaneous left/right
    for (int i = 0; i < 16; i++) press(0, 1, 0, 4, 6);
    press(1, 0, 0, 4, 6);
    press(1, 0, 0, 4, 6);
    press(1, 1, 0, 5, 6);

    // Type 1 shot, second fire inside cooldown dropped
    set_type(1);
    press(0, 0, 1, 4, 6);
    press(0, 0, 1, 4, 20);

    // Laser charges run out
    set_type(3);
    press(0, 0, 1, 4, 36);
    press(0, 0, 1, 4, 36);
    press(0, 0, 1, 4, 36);

    // Safe switch, then switch moved mid-cooldown
    set_type(0);
    press(0, 0, 1, 4, 10);
    set_type(1);
    press(0, 0, 1, 4, 6);
    set_type(2);
    tick(15);
    end_checks();

    // Rotation in the acceptance cycle lands after the pulse
    press(0, 1, 1, 4, 30);

    // Reset mid-cooldown, then an immediate fire
    set_type(1);
    press(0, 0, 1, 4, 6);
    do_reset();
    press(0, 0, 1, 4, 20);

    // Random traffic
    for (int i = 0; i < 80; i++) begin
      int op;
      int hold;
      int gap;
      op   = $urandom_range(0, 8);
      hold = $urandom_range(DEB, DEB + 4);
      gap  = $urandom_range(6, 20);
      case (op)
        0: press(1, 0, 0, hold, gap);
        1: press(0, 1, 0, hold, gap);
        2: press(1, 1, 0, hold, gap);
        3: press(0, 0, 1, hold, gap);
        4: press(0, 1, 1, hold, gap);
        5: press(1, 0, 1, hold, gap);
        6: press($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 1'b1,
                 $urandom_range(1, DEB - 1), gap);
        7: set_type($urandom_range(0, 3));
        default: begin
          if ($urandom_range(0, 3) == 0) do_reset();
          else tick(gap);
        end
      endcase
    end

    tick(50);
    check("scoreboard_drained", exp_q.size(), 0);
    end_checks();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
